// File: rtl/fm_modulator_if.sv
// Audio sample stream into the FM modulator: one signed 16-bit sample per
// valid/ready transfer.
interface fm_modulator_if;
    logic [15:0] audio_data;
    logic        audio_valid;
    logic        audio_ready;

    modport master (output audio_data, output audio_valid, input audio_ready);
    modport slave  (input audio_data, input audio_valid, output audio_ready);
endinterface

// File: rtl/fm_modulator.sv
// FM transmit modulator: buffered audio scales a deviation term added to the
// carrier word, driving a phase accumulator and a quarter-wave sine LUT.
module fm_modulator #(
    parameter int PHASE_W   = 32,
    parameter int LUT_AW    = 8,
    parameter int OUT_W     = 16,
    parameter int RATE      = 64,
    parameter int DEV_SHIFT = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               enable,
    input  logic [PHASE_W-1:0] fcw_carrier,
    input  logic [15:0]        dev_gain,
    fm_modulator_if.slave      audio,
    output logic [OUT_W-1:0]   mod_out,
    output logic               mod_valid,
    output logic               underrun
);
    localparam int CNT_W = (RATE > 2) ? $clog2(RATE) : 1;
    localparam int LUT_N = 2 ** LUT_AW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE - 1);

    typedef enum logic { IDLE, RUN } state_e;

    // Quarter-wave table, offset by half a step so no entry is zero.
    function automatic int lut_entry(input int idx);
        real amp, ang;
        amp = $itor((2 ** (OUT_W - 1)) - 1);
        ang = 2.0 * 3.14159265358979 * ($itor(idx) + 0.5) / $itor(2 ** (LUT_AW + 2));
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

    logic [OUT_W-1:0] lut_rom [LUT_N];
    for (genvar g = 0; g < LUT_N; g++) begin : g_lut
        localparam int ENTRY = lut_entry(g);
        assign lut_rom[g] = OUT_W'(ENTRY);
    end

    state_e              state_q, state_d;
    logic                buf_full_q, buf_full_d;
    logic [15:0]         buf_data_q, buf_data_d;
    logic signed [15:0]  cur_sample_q, cur_sample_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                underrun_q, underrun_d;
    logic [PHASE_W-1:0]  fw_q, fw_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [1:0]          quad_q, quad_d;
    logic [LUT_AW-1:0]   addr_q, addr_d;
    logic                v1_q, v1_d, v2_q, v2_d;
    logic [OUT_W-1:0]    mod_out_q, mod_out_d;
    logic                mod_valid_q, mod_valid_d;

    logic signed [32:0]  prod, dev_sh;
    logic [PHASE_W-1:0]  dev_ext;
    logic [LUT_AW-1:0]   lut_addr;
    logic [OUT_W-1:0]    lut_val;

    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // block leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        buf_full_d   = buf_full_q;
        buf_data_d   = buf_data_q;
        cur_sample_d = cur_sample_q;
        cnt_d        = cnt_q;
        underrun_d   = underrun_q;

        prod    = 33'(cur_sample_q) * 33'($signed({1'b0, dev_gain}));
        dev_sh  = prod >>> DEV_SHIFT;
        dev_ext = PHASE_W'(dev_sh);

        // Accept is exclusive with consume: it needs the buffer empty.
        if (audio.audio_valid && !buf_full_q) begin
            buf_full_d = 1'b1;
            buf_data_d = audio.audio_data;
        end

        if (state_q == IDLE) begin
            fw_d         = '0;
            phase_d      = '0;
            cur_sample_d = '0;
            cnt_d        = '0;
            if (enable && buf_full_q) begin
                state_d      = RUN;
                cur_sample_d = buf_data_q;
                buf_full_d   = 1'b0;
            end
        end else begin
            fw_d    = fcw_carrier + dev_ext;
            phase_d = phase_q + fw_q;
            if (!enable) begin
                state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (buf_full_q) begin
                    cur_sample_d = buf_data_q;
                    buf_full_d   = 1'b0;
                end else begin
                    underrun_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        quad_d = phase_q[PHASE_W-1 -: 2];
        addr_d = phase_q[PHASE_W-3 -: LUT_AW];
        v1_d   = (state_q == RUN);
        v2_d   = v1_q;

        lut_addr    = quad_q[0] ? ~addr_q : addr_q;
        lut_val     = lut_rom[lut_addr];
        mod_out_d   = v2_q ? (quad_q[1] ? -lut_val : lut_val) : '0;
        mod_valid_d = v2_q;
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge
        // value of the others, independent of statement order.
        if (sys_rst) begin
            state_q      <= IDLE;
            buf_full_q   <= 1'b0;
            buf_data_q   <= '0;
            cur_sample_q <= '0;
            cnt_q        <= '0;
            underrun_q   <= 1'b0;
            fw_q         <= '0;
            phase_q      <= '0;
            quad_q       <= '0;
            addr_q       <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            mod_out_q    <= '0;
            mod_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_full_q   <= buf_full_d;
            buf_data_q   <= buf_data_d;
            cur_sample_q <= cur_sample_d;
            cnt_q        <= cnt_d;
            underrun_q   <= underrun_d;
            fw_q         <= fw_d;
            phase_q      <= phase_d;
            quad_q       <= quad_d;
            addr_q       <= addr_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            mod_out_q    <= mod_out_d;
            mod_valid_q  <= mod_valid_d;
        end
    end

    assign audio.audio_ready = !buf_full_q;
    assign mod_out           = mod_out_q;
    assign mod_valid         = mod_valid_q;
    assign underrun          = underrun_q;
endmodule

// File: doc/fm_modulator.md
# fm_modulator

FM transmit modulator for the baseband-to-IF path. It runs in the opposite direction to the receive chain, which mixes the FM input down and then filters it. Signed audio samples arrive on a valid/ready handshake. Each sample is held for `RATE` clocks and scaled by a programmable deviation gain. The result is added to a carrier frequency word that drives a phase accumulator and a quarter-wave sine LUT, producing a signed FM carrier sample on every clock.

## Interface
Parameters:
- `PHASE_W`, 32: phase accumulator and frequency word width.
- `LUT_AW`, 8: quarter-wave LUT address width (256 entries).
- `OUT_W`, 16: output sample width.
- `RATE`, 64: clocks per audio sample; must be ≥ 2.
- `DEV_SHIFT`, 8: arithmetic right shift applied to the deviation product.

Ports:
- `sys_clk` in 1: single clock; all logic on the rising edge.
- `sys_rst` in 1: synchronous, active-high reset.
- `enable` in 1: run request.
- `fcw_carrier` in PHASE_W: unsigned carrier frequency word; sampled every clock.
- `dev_gain` in 16: unsigned deviation gain; sampled every clock.
- `audio_data` in 16: signed audio sample.
- `audio_valid` in 1: `audio_data` is valid.
- `audio_ready` out 1: the holding buffer is empty.
- `mod_out` out OUT_W: signed modulated carrier.
- `mod_valid` out 1: `mod_out` is meaningful.
- `underrun` out 1: sticky flag; set when a sample period ends with the buffer empty.

## Operation
- Holding buffer: one entry.
  - `audio_ready = !buf_full`, driven directly from the register, with no combinational path from `audio_valid`.
  - A transfer occurs when `audio_valid && audio_ready`.
- State machine, two states:
  - IDLE → RUN when `enable && buf_full`. On entry, the buffer is consumed into `cur_sample` and the period counter is set to 0.
  - RUN → IDLE on the cycle after `enable` falls. In IDLE, phase is forced to 0, `cur_sample` to 0 and the counter to 0.
- Period counter (RUN only):
  - Counts 0..RATE-1 and wraps.
  - At count RATE-1, if `buf_full`: load `cur_sample` from the buffer and clear `buf_full`.
  - At count RATE-1, if the buffer is empty: keep `cur_sample` and set `underrun`.
- Simultaneous consume and accept cannot happen, because `audio_ready` is low while the buffer is full. A buffer emptied at cycle t accepts new data from t+1.
- Frequency word:
  - `prod = audio * dev_gain`, 33-bit signed, with `dev_gain` zero-extended.
  - `dev = prod >>> DEV_SHIFT`, sign-extended to PHASE_W.
  - `fw = fcw_carrier + dev` mod 2^PHASE_W. Registered.
- Phase: `phase <= phase + fw` mod 2^PHASE_W in RUN. Wraps silently.
- Sine lookup:
  - Quadrant is `phase[PHASE_W-1:PHASE_W-2]`; address is the next LUT_AW bits.
  - Quadrants 1 and 3 use the address `~addr`. Quadrants 2 and 3 negate the LUT value.
  - `LUT[i] = round((2^(OUT_W-1)-1) * sin(2π(i+0.5)/2^(LUT_AW+2)))`. All entries are positive, so negation never overflows.
- Reset values: `mod_out` 0, `mod_valid` 0, `underrun` 0, `audio_ready` 1, state IDLE, phase 0, buffer empty.
- `underrun` clears only on `sys_rst`.

## Timing
- Pipeline: `fw` register → `phase` register → quadrant/address register → LUT and sign output register.
- `mod_out` at cycle t reflects the phase value of cycle t-2.
- A change in `cur_sample` or `fcw_carrier` at cycle t first affects `phase` at t+2 and `mod_out` at t+4.
- `mod_valid` rises 3 cycles after IDLE → RUN and falls 3 cycles after RUN → IDLE.
- While `mod_valid` is 0, `mod_out` is 0. Pipeline registers flush to 0 in IDLE.
- Reset mid-operation: all state returns to the reset values on the next edge, and a buffered sample is discarded.

## Test plan
- Reset: assert `sys_rst` for 2 cycles with `audio_valid=1` → `audio_ready=1`, `mod_valid=0`, `mod_out=0`, `underrun=0`; no transfer occurs during reset.
- Pure carrier: `audio=0`, `fcw_carrier=2^30`, `enable=1` after one sample accepted → `mod_out` cycles LUT[0] (≈101), LUT[255] (≈32767), -LUT[0], -LUT[255] with period 4.
- Deviation:
  - Stimulus: `fcw_carrier=0`, `dev_gain=256`, `DEV_SHIFT=8`, audio=+1000.
  - Required: phase increment 1000 per clock.
  - Then: audio=-1000 → phase decreases by 1000 per clock, wrapping from 0 to 2^32-1000.
- Handshake: hold `audio_valid=1` continuously → exactly one transfer every RATE=64 clocks in RUN, and `audio_ready` low between transfers.
- Underrun: supply one sample, then none → `underrun` set at count 63 of the first period; the last sample is held; the flag stays set after data resumes.
- Enable drop mid-period: `enable=0` at count 20 → IDLE next cycle, `mod_valid=0` 3 cycles later; the buffered sample is retained for the next RUN.
